instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   CPU-side initiator for the instruction memory port. Holds the fetch PC and drives the word address/read strobe.
//   Honours BUSYWAIT and registers each returned word, with its PC, into a one-entry output slot for the decode stage.
//   Supports branch/jump redirects, including a redirect that arrives while a memory access is still busy.
// PARAMETERS
//   RESET_PC   32'h0000_0000  first fetch address after reset (bits [1:0] forced to 00)
// PORTS
//   CLK             in   1   clock; all state updates on posedge
//   RESET           in   1   asynchronous, active-high reset
//   IMEM_ADDRESS    out  32  word-aligned fetch address to instruction memory
//   IMEM_READ       out  1   read request strobe
//   IMEM_READDATA   in   32  instruction word; little-endian byte lanes, valid when IMEM_BUSYWAIT=0
//   IMEM_BUSYWAIT   in   1   1 = access in progress; address must be held stable
//   BRANCH_TAKEN    in   1   redirect request from execute; 1-cycle pulse
//   BRANCH_TARGET   in   32  redirect address; bits [1:0] ignored
//   STALL           in   1   decode cannot accept; held output must not change
//   INSTRUCTION     out  32  fetched instruction word
//   PC_OUT          out  32  address INSTRUCTION was fetched from
//   VALID           out  1   INSTRUCTION/PC_OUT hold a live instruction
// BEHAVIOUR
//   Reset (async, any time, mid-access included):
//   - state=IDLE, fetch PC=RESET_PC, pending target=0, IMEM_READ=0, IMEM_ADDRESS=RESET_PC.
//   - INSTRUCTION=0, PC_OUT=0, VALID=0. Any in-flight access is abandoned.
//   States:
//   - IDLE: IMEM_READ=0. Always goes to FETCH at the next edge. A BRANCH_TAKEN on that edge loads PC=target.
//   - FETCH: IMEM_READ=1, IMEM_ADDRESS=PC.
//   - DISCARD: IMEM_READ=1, IMEM_ADDRESS=PC (the old address, held). Used to drain a busy access after a redirect.
//   Capture, evaluated at the edge in FETCH:
//   - take = !IMEM_BUSYWAIT && (!VALID || !STALL) && !BRANCH_TAKEN.
//   - On take: INSTRUCTION<=IMEM_READDATA, PC_OUT<=PC, VALID<=1, PC<=PC+4.
//   - PC increment is modulo 2^32 (32'hFFFF_FFFC -> 0).
//   - If VALID && !STALL && !take, then VALID<=0 (slot consumed, nothing new).
//   - If STALL && VALID: outputs are frozen and PC is held. The same address is re-read until the slot frees.
//   Throughput and latency:
//   - 1 instruction/cycle with BUSYWAIT=0 and no STALL.
//   - Address to VALID latency is 1 edge, plus N edges for N busy cycles.
//   Redirect (BRANCH_TAKEN=1 at an edge) has priority over capture and STALL:
//   - VALID<=0 in all states; the returned word is never delivered.
//   - FETCH with IMEM_BUSYWAIT=0: PC<=BRANCH_TARGET&~3, stay FETCH. The next edge fetches the target.
//   - FETCH with IMEM_BUSYWAIT=1: pending<=target&~3, go DISCARD. IMEM_ADDRESS stays at old PC.
//   - DISCARD: pending is overwritten by the newest target (last redirect wins).
//   - DISCARD with IMEM_BUSYWAIT=0 at the edge: PC<=pending, go FETCH. The drained data is dropped.
//   - IDLE: PC<=target&~3.
//   IMEM_ADDRESS never changes while IMEM_BUSYWAIT=1 (outside reset).
//   No other outputs change while STALL=1 && VALID=1, except VALID falling on a redirect.
// TESTING
//   1 Reset with RESET_PC=0, memory loaded 0..16, BUSYWAIT=0, STALL=0.
//     -> VALID rises 2 edges after reset release; PC_OUT = 0,4,8,12,16 on consecutive cycles with matching words.
//   2 BUSYWAIT held 3 cycles on address 8.
//     -> IMEM_ADDRESS stays 8 throughout; VALID=0 in that window; word@8 delivered on the edge BUSYWAIT falls; no skipped PC.
//   3 STALL=1 for 4 cycles while PC_OUT=4.
//     -> INSTRUCTION/PC_OUT frozen at 4; after release the next delivered PC is 8, with no duplicate and no loss.
//   4 BRANCH_TAKEN to 0x103 with BUSYWAIT=0.
//     -> VALID=0 next cycle; IMEM_ADDRESS=0x100; next delivered PC_OUT=0x100.
//   5 BRANCH_TAKEN to 0x40 during BUSYWAIT, then to 0x80 while still busy.
//     -> address held at old PC until BUSYWAIT falls; old word dropped; first delivered PC_OUT=0x80.
//   6 Assert RESET mid-BUSYWAIT at PC=0x20, and separately run PC up to 32'hFFFF_FFFC.
//     -> reset: all outputs to reset values immediately, refetch from RESET_PC; run: next fetch address is 0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory port between fetch unit and memory
interface instruction_fetch_unit_if;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_readdata;
  logic        imem_busywait;

  modport master (
    output imem_address,
    output imem_read,
    input  imem_readdata,
    input  imem_busywait
  );

  modport slave (
    input  imem_address,
    input  imem_read,
    output imem_readdata,
    output imem_busywait
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, memory read sequencing, redirects and one-entry decode slot
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_unit_if.master  imem,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  input  logic                      stall,
  output logic [31:0]               instruction,
  output logic [31:0]               pc_out,
  output logic                      valid
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pending, pending_n;
  logic [31:0] instruction_n;
  logic [31:0] pc_out_n;
  logic        valid_n;
  logic [31:0] target_aligned;
  logic        take;

  assign target_aligned    = branch_target & ~32'h3;
  assign imem.imem_address = pc;
  assign imem.imem_read    = (state != IDLE);

  // A word is accepted only when memory is done, the slot is free or draining, and no redirect kills it.
  assign take = (state == FETCH) && !imem.imem_busywait && (!valid || !stall) && !branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC_ALIGNED;
      pending     <= 32'h0;
      instruction <= 32'h0;
      pc_out      <= 32'h0;
      valid       <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pending     <= pending_n;
      instruction <= instruction_n;
      pc_out      <= pc_out_n;
      valid       <= valid_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pending_n     = pending;
    instruction_n = instruction;
    pc_out_n      = pc_out;
    valid_n       = valid;

    case (state)
      IDLE: begin
        state_n = FETCH;
        if (branch_taken) begin
          pc_n    = target_aligned;
          valid_n = 1'b0;
        end
      end

      FETCH: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          if (imem.imem_busywait) begin
            pending_n = target_aligned;
            state_n   = DISCARD;
          end else begin
            pc_n = target_aligned;
          end
        end else if (take) begin
          instruction_n = imem.imem_readdata;
          pc_out_n      = pc;
          valid_n       = 1'b1;
          pc_n          = pc + 32'd4;
        end else if (valid && !stall) begin
          valid_n = 1'b0;
        end
      end

      DISCARD: begin
        // The newest redirect wins, even on the edge the drained access completes.
        if (branch_taken) begin
          pending_n = target_aligned;
          valid_n   = 1'b0;
        end
        if (!imem.imem_busywait) begin
          pc_n    = branch_taken ? target_aligned : pending;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;

  int tests_run;
  int tests_failed;

  instruction_fetch_unit_if mif ();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (mif.master),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .valid         (valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  always_comb mif.imem_readdata = mem_word(mif.imem_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the unit with pc_out=0 delivered and address 4 on the bus.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_slot(input string tag, input logic [31:0] exp_pc);
    check({tag, ".valid"}, {31'b0, valid}, 32'd1);
    check({tag, ".pc_out"}, pc_out, exp_pc);
    check({tag, ".instr"}, instruction, mem_word(exp_pc));
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    rst               = 1'b1;
    branch_taken      = 1'b0;
    branch_target     = 32'h0;
    stall             = 1'b0;
    mif.imem_busywait = 1'b0;

    // 1: reset state and streaming from RESET_PC
    tick();
    check("rst.valid", {31'b0, valid}, 32'd0);
    check("rst.instr", instruction, 32'h0);
    check("rst.pc_out", pc_out, 32'h0);
    check("rst.read", {31'b0, mif.imem_read}, 32'd0);
    check("rst.addr", mif.imem_address, 32'h0);
    rst = 1'b0;
    tick();
    check("t1.valid_e1", {31'b0, valid}, 32'd0);
    check("t1.read_e1", {31'b0, mif.imem_read}, 32'd1);
    check("t1.addr_e1", mif.imem_address, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_slot("t1.stream", 32'(i * 4));
    end

    // 2: busywait held 3 cycles on address 8
    do_reset();
    tick();
    check_slot("t2.pre", 32'h4);
    mif.imem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2.addr_held", mif.imem_address, 32'h8);
      check("t2.valid_low", {31'b0, valid}, 32'd0);
    end
    mif.imem_busywait = 1'b0;
    tick();
    check_slot("t2.deliver", 32'h8);
    tick();
    check_slot("t2.next", 32'hC);

    // 3: stall for 4 cycles while pc_out=4
    do_reset();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_slot("t3.frozen", 32'h4);
      check("t3.addr", mif.imem_address, 32'h8);
    end
    stall = 1'b0;
    tick();
    check_slot("t3.release", 32'h8);
    tick();
    check_slot("t3.next", 32'hC);

    // 4: redirect to 0x103 with no busywait
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    check("t4.valid_low", {31'b0, valid}, 32'd0);
    check("t4.addr", mif.imem_address, 32'h100);
    tick();
    check_slot("t4.target", 32'h100);

    // 5: two redirects during a busy access, last one wins
    mif.imem_busywait = 1'b1;
    tick();
    check("t5.addr_busy", mif.imem_address, 32'h104);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    check("t5.addr_br1", mif.imem_address, 32'h104);
    check("t5.valid_br1", {31'b0, valid}, 32'd0);
    branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    check("t5.addr_br2", mif.imem_address, 32'h104);
    tick();
    check("t5.addr_drain", mif.imem_address, 32'h104);
    mif.imem_busywait = 1'b0;
    tick();
    check("t5.valid_drop", {31'b0, valid}, 32'd0);
    check("t5.addr_tgt", mif.imem_address, 32'h80);
    tick();
    check_slot("t5.first", 32'h80);

    // 6a: asynchronous reset in the middle of a busy access at 0x20
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    tick();
    branch_taken      = 1'b0;
    mif.imem_busywait = 1'b1;
    tick();
    check("t6.addr_busy", mif.imem_address, 32'h20);
    #2;
    rst = 1'b1;
    #1;
    check("t6.async_valid", {31'b0, valid}, 32'd0);
    check("t6.async_pc_out", pc_out, 32'h0);
    check("t6.async_instr", instruction, 32'h0);
    check("t6.async_read", {31'b0, mif.imem_read}, 32'd0);
    check("t6.async_addr", mif.imem_address, 32'h0);
    mif.imem_busywait = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_slot("t6.refetch", 32'h0);

    // 6b: PC wraps from 0xFFFF_FFFC to 0
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    tick();
    branch_taken = 1'b0;
    check("t6.addr_fff8", mif.imem_address, 32'hFFFF_FFF8);
    tick();
    check_slot("t6.fff8", 32'hFFFF_FFF8);
    tick();
    check_slot("t6.fffc", 32'hFFFF_FFFC);
    check("t6.wrap_addr", mif.imem_address, 32'h0);
    tick();
    check_slot("t6.wrap", 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
